// File: rtl/im_arb_pkg.sv
// Shared types and helpers for the instruction-memory fetch arbiter.
package im_arb_pkg;

    localparam int IM_ADDR_W = 16;
    localparam int IM_DATA_W = 16;

    typedef struct packed {
        logic [IM_ADDR_W-1:0] pc;
        logic [IM_DATA_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ISS_NONE  = 2'd0,
        ISS_FETCH = 2'd1,
        ISS_DBG   = 2'd2
    } issue_src_t;

    // Sequential PC step that wraps to zero after the last IM word.
    function automatic logic [IM_ADDR_W-1:0] pc_wrap_inc(
        input logic [IM_ADDR_W-1:0] pc,
        input logic [IM_ADDR_W-1:0] last_pc
    );
        return (pc == last_pc) ? '0 : pc + IM_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/im_prefetch_fifo.sv
// Small prefetch queue of {pc, instr}; head is always readable, flush empties it.
module im_prefetch_fifo
    import im_arb_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  entry_t                       wr_entry,
    output entry_t                       head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               push_ok;
    logic               pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty && !flush;
    // A push into a full queue is legal only alongside a pop.
    assign push_ok = push && !flush && (!full || pop_ok);

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= wr_entry;
                end
            end
        end
    endgenerate

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/im_fetch_arbiter.sv
// Shares the single IM read port between the prefetch queue and a debug reader,
// with branch-redirect flush and a 1-in-2 cap on debug slots.
module im_fetch_arbiter
    import im_arb_pkg::*;
#(
    parameter int ADDR_W   = IM_ADDR_W,
    parameter int DATA_W   = IM_DATA_W,
    parameter int DEPTH    = 4,
    parameter int IM_WORDS = 1024,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] im_addr,
    output logic              im_rd_en,
    input  logic [DATA_W-1:0] im_instr,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_vld,
    input  logic              instr_rdy,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_vld,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int                CNT_W   = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(IM_WORDS - 1);

    issue_src_t         issue_src_reg;
    issue_src_t         issue_src_next;
    logic [ADDR_W-1:0]  im_addr_reg;
    logic [ADDR_W-1:0]  im_addr_next;
    logic [ADDR_W-1:0]  fetch_pc_reg;
    logic [ADDR_W-1:0]  fetch_pc_next;
    logic [ADDR_W-1:0]  issue_pc;
    logic               dbg_vld_reg;
    logic [DATA_W-1:0]  dbg_data_reg;

    logic               fetch_inflight;
    logic               dbg_inflight;
    logic               fetch_credit;
    logic               fifo_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    fetch_entry_t       fifo_wr_entry;
    fetch_entry_t       fifo_head;

    assign fetch_inflight = (issue_src_reg == ISS_FETCH);
    assign dbg_inflight   = (issue_src_reg == ISS_DBG);

    // The read on the pins now lands in the queue at this edge, so it already
    // consumes a slot; a same-cycle pop is deliberately not counted.
    assign fetch_credit = fetch_inflight ? (int'(fifo_count) < DEPTH - 1) : !fifo_full;

    // Issue decision and read-port state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_src_reg <= ISS_NONE;
            im_addr_reg   <= '0;
            fetch_pc_reg  <= ADDR_W'(RESET_PC) & PC_LAST;
        end else begin
            issue_src_reg <= issue_src_next;
            im_addr_reg   <= im_addr_next;
            fetch_pc_reg  <= fetch_pc_next;
        end
    end

    // Redirect always takes the next slot, which also defers any pending debug read.
    always_comb begin
        issue_src_next = ISS_NONE;
        if (redirect) begin
            issue_src_next = ISS_FETCH;
        end else if (dbg_req && !dbg_inflight) begin
            issue_src_next = ISS_DBG;
        end else if (fetch_credit) begin
            issue_src_next = ISS_FETCH;
        end
    end

    always_comb begin
        issue_pc      = redirect ? (redirect_pc & PC_LAST) : fetch_pc_reg;
        im_addr_next  = im_addr_reg;
        fetch_pc_next = fetch_pc_reg;
        case (issue_src_next)
            ISS_FETCH: begin
                im_addr_next  = issue_pc;
                fetch_pc_next = pc_wrap_inc(issue_pc, PC_LAST);
            end
            ISS_DBG: begin
                im_addr_next = dbg_addr;
            end
            default: begin
            end
        endcase
    end

    // A fetch read on the pins during a redirect cycle is simply never pushed.
    assign fifo_push           = fetch_inflight && !redirect;
    assign fifo_wr_entry.pc    = im_addr_reg;
    assign fifo_wr_entry.instr = im_instr;

    im_prefetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .pop      (instr_rdy),
        .flush    (redirect),
        .wr_entry (fifo_wr_entry),
        .head     (fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Debug reads are unaffected by redirect; data is captured at the end of the grant cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_vld_reg  <= 1'b0;
            dbg_data_reg <= '0;
        end else begin
            dbg_vld_reg <= dbg_inflight;
            if (dbg_inflight) begin
                dbg_data_reg <= im_instr;
            end
        end
    end

    assign im_addr   = im_addr_reg;
    assign im_rd_en  = (issue_src_reg != ISS_NONE);
    assign dbg_gnt   = dbg_inflight;
    assign dbg_vld   = dbg_vld_reg;
    assign dbg_data  = dbg_data_reg;
    assign instr_vld = !fifo_empty;
    assign instr_out = fifo_empty ? '0 : fifo_head.instr;
    assign instr_pc  = fifo_empty ? '0 : fifo_head.pc;

endmodule

// File: tb/tb_im_fetch_arbiter.sv
// Bench for im_fetch_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_im_fetch_arbiter;

    localparam int DEPTH    = 4;
    localparam int IM_WORDS = 1024;

    logic        clk;
    logic        rst;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] im_instr;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_vld;
    logic        instr_rdy;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        dbg_req;
    logic [15:0] dbg_addr;
    logic        dbg_gnt;
    logic        dbg_vld;
    logic [15:0] dbg_data;

    logic [15:0] im_mem [IM_WORDS];

    int checks = 0;
    int errors = 0;

    im_fetch_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .DEPTH    (DEPTH),
        .IM_WORDS (IM_WORDS),
        .RESET_PC (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .im_addr     (im_addr),
        .im_rd_en    (im_rd_en),
        .im_instr    (im_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_vld   (instr_vld),
        .instr_rdy   (instr_rdy),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .dbg_req     (dbg_req),
        .dbg_addr    (dbg_addr),
        .dbg_gnt     (dbg_gnt),
        .dbg_vld     (dbg_vld),
        .dbg_data    (dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: data appears after the negedge of the issue cycle.
    initial begin
        im_instr = '0;
        forever begin
            @(negedge clk);
            if (im_rd_en === 1'b1) im_instr = im_mem[im_addr[9:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } ent_t;

    ent_t        m_q[$];
    int          m_kind;       // 0 none, 1 fetch, 2 debug read on the pins
    int          m_addr;
    int          m_pc;
    logic        m_dbg_vld;
    logic [15:0] m_dbg_data;

    task automatic model_reset();
        m_q.delete();
        m_kind     = 0;
        m_addr     = 0;
        m_pc       = 0;
        m_dbg_vld  = 1'b0;
        m_dbg_data = '0;
    endtask

    task automatic model_step();
        bit   push;
        ent_t e;
        int   occ;
        int   infl;
        push    = (m_kind == 1) && !redirect;
        e.pc    = m_addr[15:0];
        e.instr = im_mem[m_addr % IM_WORDS];
        m_dbg_vld = (m_kind == 2);
        if (m_dbg_vld) begin
            m_dbg_data = im_mem[m_addr % IM_WORDS];
            $display("dbg read addr=%h data=%h", m_addr[15:0], m_dbg_data);
        end
        occ  = m_q.size();
        infl = (m_kind == 1) ? 1 : 0;
        if (redirect) begin
            m_q.delete();
            $display("redirect to %h", redirect_pc);
        end else begin
            if (instr_rdy && m_q.size() > 0) begin
                $display("pop pc=%h instr=%h", m_q[0].pc, m_q[0].instr);
                void'(m_q.pop_front());
            end
            if (push) m_q.push_back(e);
        end
        if (redirect) begin
            m_pc   = int'(redirect_pc) % IM_WORDS;
            m_kind = 1;
        end else if (dbg_req && m_kind != 2) begin
            m_kind = 2;
        end else if (occ + infl < DEPTH) begin
            m_kind = 1;
        end else begin
            m_kind = 0;
        end
        if (m_kind == 2) m_addr = int'(dbg_addr);
        if (m_kind == 1) begin
            m_addr = m_pc;
            m_pc   = (m_pc + 1) % IM_WORDS;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("m_rd_en", im_rd_en, m_kind != 0);
            chk("m_addr", im_addr, m_addr[15:0]);
            chk("m_vld", instr_vld, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("m_pc", instr_pc, m_q[0].pc);
                chk("m_out", instr_out, m_q[0].instr);
            end
            chk("m_gnt", dbg_gnt, m_kind == 2);
            chk("m_dbg_vld", dbg_vld, m_dbg_vld);
            chk("m_dbg_data", dbg_data, m_dbg_data);
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, im_rd_en, 0);
        chk({tag, "_addr"}, im_addr, 0);
        chk({tag, "_vld"}, instr_vld, 0);
        chk({tag, "_out"}, instr_out, 0);
        chk({tag, "_pc"}, instr_pc, 0);
        chk({tag, "_gnt"}, dbg_gnt, 0);
        chk({tag, "_dbg_vld"}, dbg_vld, 0);
        chk({tag, "_dbg_data"}, dbg_data, 0);
    endtask

    task automatic pulse_reset(input logic rdy);
        @(negedge clk);
        rst       = 1'b1;
        instr_rdy = rdy;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int wrap_exp[4] = '{1022, 1023, 0, 1};

    initial begin
        rst         = 1'b1;
        instr_rdy   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        dbg_req     = 1'b0;
        dbg_addr    = '0;
        for (int i = 0; i < IM_WORDS; i++) im_mem[i] = 16'(32'h1000 + i);
        im_mem[16'h50] = 16'hBEEF;

        // 1: streaming fetch from reset
        repeat (3) @(negedge clk);
        chk_reset_outputs("t1_rst");
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("t1_rd_en", im_rd_en, 1);
            chk("t1_addr", im_addr, k - 1);
            if (k >= 2) begin
                chk("t1_vld", instr_vld, 1);
                chk("t1_pc", instr_pc, k - 2);
                chk("t1_out", instr_out, 32'h1000 + k - 2);
            end else begin
                chk("t1_vld0", instr_vld, 0);
            end
        end

        // 2: consumer stalled, queue fills to DEPTH
        pulse_reset(1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t2_rd_en", im_rd_en, 1);
            chk("t2_addr", im_addr, k - 1);
        end
        for (int k = 5; k <= 7; k++) begin
            @(negedge clk);
            chk("t2_idle", im_rd_en, 0);
        end
        chk("t2_head", instr_pc, 0);
        instr_rdy = 1'b1;
        @(negedge clk);
        instr_rdy = 1'b0;
        chk("t2_no_credit", im_rd_en, 0);
        chk("t2_head2", instr_pc, 1);
        @(negedge clk);
        chk("t2_refill_en", im_rd_en, 1);
        chk("t2_refill_addr", im_addr, 4);

        // 3: redirect during a steady stream
        pulse_reset(1'b1);
        repeat (5) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 16'h0123;
        @(negedge clk);
        redirect = 1'b0;
        chk("t3_addr", im_addr, 16'h0123);
        chk("t3_vld", instr_vld, 0);
        @(negedge clk);
        chk("t3_vld2", instr_vld, 1);
        chk("t3_pc", instr_pc, 16'h0123);
        chk("t3_out", instr_out, 16'h1123);
        @(negedge clk);
        chk("t3_pc2", instr_pc, 16'h0124);

        // 4: redirect with high bits set, PC wraps at the top of IM
        redirect    = 1'b1;
        redirect_pc = 16'hFBFE;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j == 0) redirect = 1'b0;
            chk("t4_addr", im_addr, wrap_exp[j]);
            if (j == 1) begin
                chk("t4_pc", instr_pc, 16'h03FE);
                chk("t4_out", instr_out, 16'h13FE);
            end
        end

        // 5: held debug request alternates with fetches
        dbg_req  = 1'b1;
        dbg_addr = 16'h0050;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk("t5_gnt", dbg_gnt, j % 2);
            if (j % 2 == 1) begin
                chk("t5_addr", im_addr, 16'h0050);
            end else begin
                chk("t5_fetch_gap", im_rd_en, 1);
                chk("t5_dbg_vld", dbg_vld, 1);
                chk("t5_dbg_data", dbg_data, 16'hBEEF);
            end
        end
        dbg_req = 1'b0;
        @(negedge clk);
        chk("t5_gnt_end", dbg_gnt, 0);
        chk("t5_vld_end", dbg_vld, 0);
        chk("t5_data_hold", dbg_data, 16'hBEEF);

        // 5b: redirect and debug request together
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        dbg_req     = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        chk("t5b_gnt0", dbg_gnt, 0);
        chk("t5b_addr", im_addr, 16'h0200);
        @(negedge clk);
        dbg_req = 1'b0;
        chk("t5b_gnt1", dbg_gnt, 1);
        chk("t5b_dbg_addr", im_addr, 16'h0050);
        @(negedge clk);
        chk("t5b_dbg_vld", dbg_vld, 1);

        // 6: reset while a debug read and fetches are pending
        pulse_reset(1'b0);
        repeat (3) @(negedge clk);
        dbg_req = 1'b1;
        @(negedge clk);
        dbg_req = 1'b0;
        chk("t6_gnt_a", dbg_gnt, 1);
        @(negedge clk);
        chk("t6_dbg_data", dbg_data, 16'hBEEF);
        dbg_req = 1'b1;
        @(negedge clk);
        chk("t6_gnt_b", dbg_gnt, 1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("t6_rst");
        dbg_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        instr_rdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t6_no_dbg_vld", dbg_vld, 0);
            chk("t6_no_gnt", dbg_gnt, 0);
            if (k == 1) begin
                chk("t6_restart_en", im_rd_en, 1);
                chk("t6_restart_addr", im_addr, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
